// File: rtl/polyphase_slicer_pkg.sv
// Shared constants and helpers for the polyphase I/Q slicer.
// Symbol field layout, slicing modes and saturating magnitude.
package polyphase_slicer_pkg;

  localparam logic MODE_PAM2 = 1'b0;
  localparam logic MODE_PAM4 = 1'b1;

  localparam int SYM_SIGN  = 1;
  localparam int SYM_OUTER = 0;

  localparam int MAXW = 32;

  // |x| for a dw-bit two's complement value carried sign-extended in MAXW
  // bits; the most negative code folds onto the largest positive one.
  function automatic logic [MAXW-1:0] sat_abs(
    input logic signed [MAXW-1:0] x,
    input int                     dw
  );
    logic [MAXW-1:0] lim;
    logic [MAXW-1:0] mag;
    lim = (MAXW'(1) << (dw - 1)) - MAXW'(1);
    mag = x[MAXW-1] ? MAXW'(-x) : MAXW'(x);
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/polyphase_slicer_iq_rail.sv
// One rail of the slicer: sign/magnitude decision and its output register.
// The decision only updates on a load strobe and holds otherwise.
module slicer_rail
  import polyphase_slicer_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic signed [DW-1:0] x_i,
  input  logic        [DW-2:0] thr_i,
  input  logic                 mode_i,
  input  logic                 load_i,
  output logic        [1:0]    sym_o
);

  logic [DW-2:0] mag;
  logic          outer;
  logic [1:0]    sym_d;
  logic [1:0]    sym_q;

  // slice the sample and pick the next held decision
  always_comb begin
    mag   = (DW-1)'(sat_abs(MAXW'(x_i), DW));
    outer = (mode_i == MODE_PAM4) && (mag >= thr_i);
    sym_d = sym_q;
    if (load_i) begin
      sym_d[SYM_SIGN]  = x_i[DW-1];
      sym_d[SYM_OUTER] = outer;
    end
  end

  // decision register
  always_ff @(posedge clock) begin
    if (i_reset) sym_q <= '0;
    else         sym_q <= sym_d;
  end

  assign sym_o = sym_q;

endmodule

// File: rtl/polyphase_slicer_iq.sv
// Decimating I/Q slicer with manual or windowed max-energy phase pick.
// Phase changes only take effect on symbol boundaries.
module polyphase_slicer_iq
  import polyphase_slicer_pkg::*;
#(
  parameter  int OS      = 4,
  parameter  int DW      = 8,
  parameter  int LOG_WIN = 6,
  localparam int PW      = $clog2(OS)
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic signed [DW-1:0] i_firI,
  input  logic signed [DW-1:0] i_firQ,
  input  logic                 i_mode,
  input  logic        [DW-2:0] i_thr,
  input  logic                 i_auto,
  input  logic        [PW-1:0] i_phase,
  output logic        [1:0]    o_symI,
  output logic        [1:0]    o_symQ,
  output logic                 o_valid,
  output logic        [PW-1:0] o_phase,
  output logic                 o_win_done
);

  localparam int AW = DW + LOG_WIN + 1;

  logic               take;
  logic               last;
  logic               wend;
  logic               load;
  logic [PW-1:0]      req;
  logic [PW-1:0]      best;
  logic [AW-1:0]      best_v;
  logic [AW-1:0]      energy;
  logic [AW-1:0]      upd    [OS];
  logic [AW-1:0]      acc_d  [OS];
  logic [AW-1:0]      acc_q  [OS];
  logic [PW-1:0]      ph_d,   ph_q;
  logic [PW-1:0]      sel_d,  sel_q;
  logic [PW-1:0]      auto_d, auto_q;
  logic [LOG_WIN-1:0] win_d,  win_q;
  logic               valid_q;
  logic               done_q;

  // phase tracking, energy accumulation, argmax and phase latch
  always_comb begin
    take   = i_enable && i_valid;
    last   = (ph_q == PW'(OS - 1));
    wend   = take && last && (win_q == '1);
    load   = take && (ph_q == sel_q);
    energy = AW'((DW-1)'(sat_abs(MAXW'(i_firI), DW)))
           + AW'((DW-1)'(sat_abs(MAXW'(i_firQ), DW)));

    if (int'(i_phase) >= OS) req = PW'(OS - 1);
    else                     req = i_phase;
    if (i_auto) req = auto_q;

    for (int p = 0; p < OS; p++) begin
      upd[p] = acc_q[p];
      if (take && (ph_q == PW'(p))) upd[p] = acc_q[p] + energy;
    end

    best   = '0;
    best_v = upd[0];
    for (int p = 1; p < OS; p++) begin
      if (upd[p] > best_v) begin
        best_v = upd[p];
        best   = PW'(p);
      end
    end

    ph_d   = ph_q;
    sel_d  = sel_q;
    auto_d = auto_q;
    win_d  = win_q;
    for (int p = 0; p < OS; p++) acc_d[p] = upd[p];

    if (take) begin
      ph_d = last ? '0 : ph_q + PW'(1);
      if (last) begin
        sel_d = req;
        win_d = win_q + LOG_WIN'(1);
      end
    end

    if (wend) begin
      auto_d = best;
      win_d  = '0;
      for (int p = 0; p < OS; p++) acc_d[p] = '0;
    end
  end

  // state and strobe registers
  always_ff @(posedge clock) begin
    if (i_reset) begin
      ph_q    <= '0;
      sel_q   <= '0;
      auto_q  <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int p = 0; p < OS; p++) acc_q[p] <= '0;
    end else begin
      ph_q    <= ph_d;
      sel_q   <= sel_d;
      auto_q  <= auto_d;
      win_q   <= win_d;
      valid_q <= load;
      done_q  <= wend;
      for (int p = 0; p < OS; p++) acc_q[p] <= acc_d[p];
    end
  end

  slicer_rail #(.DW(DW)) u_rail_i (
    .clock   (clock),
    .i_reset (i_reset),
    .x_i     (i_firI),
    .thr_i   (i_thr),
    .mode_i  (i_mode),
    .load_i  (load),
    .sym_o   (o_symI)
  );

  slicer_rail #(.DW(DW)) u_rail_q (
    .clock   (clock),
    .i_reset (i_reset),
    .x_i     (i_firQ),
    .thr_i   (i_thr),
    .mode_i  (i_mode),
    .load_i  (load),
    .sym_o   (o_symQ)
  );

  assign o_valid    = valid_q;
  assign o_win_done = done_q;
  assign o_phase    = sel_q;

endmodule
